angle_positioner: RTL and testbench
===================================

Name: angle_positioner

Overview:
- Downstream of the manual angle/reflector command stage.
- Consumes a committed 5-bit panel angle and 1-bit reflector setpoint, then drives a stepper driver (step/dir) until the tracked position equals the target.
- After the move it actuates the reflector and waits a settle time before reporting completion.
- Sits between the control FSM and the motor/actuator driver pins.

Parameters:
- STEPS_PER_UNIT, 4, motor steps per angle LSB.
- STEP_DIV, 1000, clk cycles for each step-high and each step-low phase.
- REFL_SETTLE, 5000, clk cycles to wait after any reflector change.
- ANGLE_MAX, 24, largest legal angle code; larger targets are clamped.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- res_n  in  1  synchronous, active-low reset.
- cmd_load  in  1  one-cycle command strobe; samples angle_tgt/refl_tgt.
- angle_tgt  in  5  target angle code.
- refl_tgt  in  1  target reflector state.
- step  out  1  stepper step pulse.
- dir  out  1  1 = increasing angle, 0 = decreasing.
- refl_drive  out  1  reflector actuator drive.
- pos  out  5  current tracked angle code.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle pulse on command completion.
- clamp_err  out  1  sticky; set when a target > ANGLE_MAX was clamped; cleared by the next accepted in-range command or by reset.

Behaviour:
- Reset (res_n low at a clk edge): step=0, dir=0, refl_drive=0, pos=0, busy=0, done=0, clamp_err=0, state=IDLE, all counters 0.
  - Reset mid-move aborts immediately; pos returns to 0, which the system treats as the home position.
- States: IDLE, MOVE, REFL, SETTLE, DONE.
- IDLE:
  - On cmd_load=1, latch tgt=min(angle_tgt, ANGLE_MAX) and refl_tgt; set busy=1.
  - Set clamp_err if clamped, else clear it.
  - Next state: MOVE if tgt!=pos, else REFL.
- MOVE:
  - dir = (tgt>pos), fixed for the whole move.
  - step is high STEP_DIV cycles, then low STEP_DIV cycles, per step.
  - After STEPS_PER_UNIT complete pulses, pos increments or decrements by 1 on the cycle that ends the last low phase.
  - When pos reaches tgt, go to REFL; step stays 0.
  - pos never wraps: it is bounded to 0..ANGLE_MAX by construction.
- REFL:
  - If latched refl_tgt != refl_drive: update refl_drive the same cycle, load the settle counter, go to SETTLE.
  - Otherwise go to DONE.
- SETTLE: count REFL_SETTLE cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Command handling:
  - cmd_load while busy=1 is ignored; it is not queued.
  - cmd_load in the DONE cycle is also ignored.
- Latency: done asserts on cycle L after the cmd_load edge, where L = 2 + N·2·STEP_DIV·STEPS_PER_UNIT + (refl change ? 1+REFL_SETTLE : 0) and N = |tgt−pos|.
  - Zero-move with no reflector change: L=2 (IDLE→REFL→DONE).
- All outputs are registered; no combinational input-to-output paths.
- Counter widths: $clog2(max(STEP_DIV, REFL_SETTLE)+1) and $clog2(STEPS_PER_UNIT+1).

Decomposition:
- Shared package bpv_pkg holds:
  - ANGLE_W=5.
  - The positioner state enum (IDLE/MOVE/REFL/SETTLE/DONE).
  - The angle-code typedef.
- Natural sub-module: step_pulse_gen.
  - Inputs: en, STEP_DIV/STEPS_PER_UNIT parameters.
  - Outputs: step and a one-cycle unit_done strobe.
  - The top owns the FSM, pos, and the reflector/settle logic.

Test Plan (sim params: STEPS_PER_UNIT=2, STEP_DIV=2, REFL_SETTLE=4):
1. Hold res_n=0 for 3 cycles, then release → all outputs 0, busy=0, pos=0.
2. From pos=0, cmd_load with angle_tgt=3, refl_tgt=1:
   - dir=1; exactly 6 step pulses, each 2 high / 2 low.
   - pos steps 1, 2, 3.
   - refl_drive=1 after the move.
   - done pulses once at L = 2+24+5 = 31; busy drops the same cycle.
3. From pos=3, refl=1, cmd_load with angle_tgt=1, refl_tgt=1 → dir=0, 4 pulses, pos=1, no settle, done at L=18.
4. cmd_load with angle_tgt=31 → tgt clamped to 24, clamp_err=1, pos ends at 24. A following cmd_load with angle_tgt=5 clears clamp_err.
5. Pulse cmd_load again with angle_tgt=0 mid-move → ignored; original target is reached; only one done pulse.
6. res_n=0 mid-MOVE at pos=2 → next edge: step=0, busy=0, pos=0, refl_drive=0; no done pulse.

Source files
------------

// File: rtl/bpv_pkg.sv
// rtl/bpv_pkg.sv - shared types and constants for the angle positioner
//
// Holds the angle-code width and type, and the positioner state encoding.
// No ports.

package bpv_pkg;

  localparam int ANGLE_W = 5;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_MOVE,
    PS_REFL,
    PS_SETTLE,
    PS_DONE
  } pos_state_t;

endpackage

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - step pulse train generator for one angle unit at a time
//
// While en is high, produces step pulses STEP_DIV cycles high then
// STEP_DIV cycles low, starting high on the first enabled edge.
// unit_done strobes during the last cycle of the STEPS_PER_UNIT-th low
// phase, so the consumer can update its position on that same edge.
//
// Ports:
//   clk        in   system clock
//   res_n      in   synchronous active-low reset
//   en         in   run request; dropping it clears the generator at once
//   step       out  registered step pulse
//   unit_done  out  one-cycle strobe, last cycle of a complete unit

module step_pulse_gen #(
  parameter int STEP_DIV       = 1000,
  parameter int STEPS_PER_UNIT = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic en,
  output logic step,
  output logic unit_done
);

  localparam int DIV_W   = $clog2(STEP_DIV + 1);
  localparam int PULSE_W = $clog2(STEPS_PER_UNIT + 1);

  logic               run;
  logic [DIV_W-1:0]   div_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic               phase_end;
  logic               last_pulse;

  assign phase_end  = (div_cnt == DIV_W'(STEP_DIV - 1));
  assign last_pulse = (pulse_cnt == PULSE_W'(STEPS_PER_UNIT - 1));
  // Depends only on registered state so the top can use it to decide
  // whether to keep en asserted without forming a loop.
  assign unit_done  = run && !step && phase_end && last_pulse;

  always_ff @(posedge clk) begin
    if (!res_n || !en) begin
      run       <= 1'b0;
      step      <= 1'b0;
      div_cnt   <= '0;
      pulse_cnt <= '0;
    end else if (!run) begin
      // First enabled edge starts the first high phase immediately.
      run       <= 1'b1;
      step      <= 1'b1;
      div_cnt   <= '0;
      pulse_cnt <= '0;
    end else if (phase_end) begin
      div_cnt <= '0;
      step    <= !step;
      if (!step) begin
        pulse_cnt <= last_pulse ? '0 : pulse_cnt + PULSE_W'(1);
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/angle_positioner.sv
// rtl/angle_positioner.sv - drives panel angle via step/dir, then reflector, then reports done
//
// Accepts a committed angle/reflector command, steps the motor until the
// tracked position equals the (clamped) target, changes the reflector if
// needed and waits for it to settle, then pulses done.
//
// Ports:
//   clk         in   system clock
//   res_n       in   synchronous active-low reset (also the home position)
//   cmd_load    in   one-cycle command strobe, accepted only when idle
//   angle_tgt   in   target angle code
//   refl_tgt    in   target reflector state
//   step        out  stepper step pulse
//   dir         out  1 = increasing angle
//   refl_drive  out  reflector actuator drive
//   pos         out  tracked angle code
//   busy        out  command in progress
//   done        out  one-cycle completion pulse
//   clamp_err   out  sticky: last accepted target exceeded ANGLE_MAX

module angle_positioner
  import bpv_pkg::*;
#(
  parameter int STEPS_PER_UNIT = 4,
  parameter int STEP_DIV       = 1000,
  parameter int REFL_SETTLE    = 5000,
  parameter int ANGLE_MAX      = 24
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               cmd_load,
  input  logic [ANGLE_W-1:0] angle_tgt,
  input  logic               refl_tgt,
  output logic               step,
  output logic               dir,
  output logic               refl_drive,
  output logic [ANGLE_W-1:0] pos,
  output logic               busy,
  output logic               done,
  output logic               clamp_err
);

  localparam int     CNT_MAX     = (STEP_DIV > REFL_SETTLE) ? STEP_DIV : REFL_SETTLE;
  localparam int     CNT_W       = $clog2(CNT_MAX + 1);
  localparam angle_t ANGLE_LIMIT = angle_t'(ANGLE_MAX);

  pos_state_t       state;
  pos_state_t       state_nxt;
  angle_t           tgt;
  angle_t           tgt_in;
  angle_t           pos_step;
  logic             refl_lat;
  logic [CNT_W-1:0] settle_cnt;
  logic             gen_en;
  logic             unit_done;

  // Generator runs exactly while the FSM is (about to be) in MOVE, so the
  // first pulse starts on the accepting edge and step drops on the edge
  // that reaches the target.
  step_pulse_gen #(
    .STEP_DIV       (STEP_DIV),
    .STEPS_PER_UNIT (STEPS_PER_UNIT)
  ) u_step_gen (
    .clk       (clk),
    .res_n     (res_n),
    .en        (gen_en),
    .step      (step),
    .unit_done (unit_done)
  );

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state <= PS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_in    = (angle_tgt > ANGLE_LIMIT) ? ANGLE_LIMIT : angle_tgt;
    pos_step  = dir ? pos + angle_t'(1) : pos - angle_t'(1);
    case (state)
      PS_IDLE: begin
        if (cmd_load) begin
          state_nxt = (tgt_in != pos) ? PS_MOVE : PS_REFL;
        end
      end
      PS_MOVE: begin
        if (unit_done && (pos_step == tgt)) begin
          state_nxt = PS_REFL;
        end
      end
      PS_REFL:   state_nxt = (refl_lat != refl_drive) ? PS_SETTLE : PS_DONE;
      PS_SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = PS_DONE;
        end
      end
      PS_DONE:   state_nxt = PS_IDLE;
      default:   state_nxt = PS_IDLE;
    endcase
    gen_en = (state_nxt == PS_MOVE);
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      tgt        <= '0;
      refl_lat   <= 1'b0;
      settle_cnt <= '0;
      dir        <= 1'b0;
      refl_drive <= 1'b0;
      pos        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clamp_err  <= 1'b0;
    end else begin
      // done is visible the cycle after DONE, together with busy falling.
      done <= (state == PS_DONE);
      case (state)
        PS_IDLE: begin
          if (cmd_load) begin
            tgt       <= tgt_in;
            refl_lat  <= refl_tgt;
            busy      <= 1'b1;
            clamp_err <= (angle_tgt > ANGLE_LIMIT);
            dir       <= (tgt_in > pos);
          end
        end
        PS_MOVE: begin
          if (unit_done) begin
            pos <= pos_step;
          end
        end
        PS_REFL: begin
          if (refl_lat != refl_drive) begin
            refl_drive <= refl_lat;
            settle_cnt <= CNT_W'(REFL_SETTLE);
          end
        end
        PS_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        PS_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_positioner.sv
// tb/tb_angle_positioner.sv - self-checking bench for angle_positioner

module tb_angle_positioner;
  import bpv_pkg::*;

  localparam int SPU  = 2;
  localparam int SD   = 2;
  localparam int RS   = 4;
  localparam int AMAX = 24;

  logic               clk = 1'b0;
  logic               res_n;
  logic               cmd_load;
  logic [ANGLE_W-1:0] angle_tgt;
  logic               refl_tgt;
  logic               step;
  logic               dir;
  logic               refl_drive;
  logic [ANGLE_W-1:0] pos;
  logic               busy;
  logic               done;
  logic               clamp_err;

  int passed = 0;
  int total  = 0;
  int m_pos  = 0;
  int m_refl = 0;

  always #5 clk = ~clk;

  angle_positioner #(
    .STEPS_PER_UNIT (SPU),
    .STEP_DIV       (SD),
    .REFL_SETTLE    (RS),
    .ANGLE_MAX      (AMAX)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .cmd_load   (cmd_load),
    .angle_tgt  (angle_tgt),
    .refl_tgt   (refl_tgt),
    .step       (step),
    .dir        (dir),
    .refl_drive (refl_drive),
    .pos        (pos),
    .busy       (busy),
    .done       (done),
    .clamp_err  (clamp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and watches the whole transaction. poke_c >= 0 pulses
  // a conflicting cmd_load after that observation cycle; -2 means "during
  // the DONE cycle"; -1 means no extra strobe.
  task automatic run_cmd(input string name, input int a, input int r, input int poke_c);
    int   t, n, lat, pc, exp_dir;
    int   first_done, n_done, rises, bad_hi, bad_lo, bad_dir;
    int   hi_len, lo_len, extra_busy, busy_pre;
    logic prev;
    t          = (a > AMAX) ? AMAX : a;
    n          = (t > m_pos) ? t - m_pos : m_pos - t;
    lat        = 2 + n * 2 * SD * SPU + ((r != m_refl) ? 1 + RS : 0);
    exp_dir    = (t > m_pos) ? 1 : 0;
    pc         = (poke_c == -2) ? lat - 1 : poke_c;
    first_done = -1;
    n_done     = 0;
    rises      = 0;
    bad_hi     = 0;
    bad_lo     = 0;
    bad_dir    = 0;
    hi_len     = 0;
    lo_len     = 0;
    extra_busy = 0;
    busy_pre   = 0;
    angle_tgt  = ANGLE_W'(a);
    refl_tgt   = r[0];
    cmd_load   = 1'b1;
    prev       = step;
    for (int c = 0; c <= lat + 3; c++) begin
      tick();
      cmd_load = 1'b0;
      if (step && !prev) begin
        rises++;
        if (rises > 1 && lo_len != SD) bad_lo++;
        hi_len = 0;
      end
      if (!step && prev) begin
        if (hi_len != SD) bad_hi++;
        lo_len = 0;
      end
      if (step) begin
        hi_len++;
        if (dir !== exp_dir[0]) bad_dir++;
      end else begin
        lo_len++;
      end
      prev = step;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (c == lat - 1) busy_pre = busy;
      if (c >= lat && busy) extra_busy++;
      if (c == pc) begin
        angle_tgt = '0;
        refl_tgt  = ~r[0];
        cmd_load  = 1'b1;
      end
    end
    chk({name, ":done_cycle"}, first_done, lat);
    chk({name, ":done_count"}, n_done, 1);
    chk({name, ":step_pulses"}, rises, n * SPU);
    chk({name, ":high_width_errs"}, bad_hi, 0);
    chk({name, ":low_width_errs"}, bad_lo, 0);
    chk({name, ":dir_errs"}, bad_dir, 0);
    chk({name, ":pos"}, pos, t);
    chk({name, ":refl_drive"}, refl_drive, r);
    chk({name, ":clamp_err"}, clamp_err, (a > AMAX) ? 1 : 0);
    chk({name, ":busy_before_done"}, busy_pre, 1);
    chk({name, ":busy_after_done"}, extra_busy, 0);
    chk({name, ":step_idle"}, step, 0);
    m_pos  = t;
    m_refl = r;
  endtask

  initial begin
    int a, r, hits, dn;

    res_n     = 1'b0;
    cmd_load  = 1'b0;
    angle_tgt = '0;
    refl_tgt  = 1'b0;
    repeat (3) tick();
    res_n = 1'b1;
    tick();
    chk("reset:step", step, 0);
    chk("reset:dir", dir, 0);
    chk("reset:refl_drive", refl_drive, 0);
    chk("reset:pos", pos, 0);
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    chk("reset:clamp_err", clamp_err, 0);

    run_cmd("up3_refl1", 3, 1, -1);
    run_cmd("down1", 1, 1, -1);
    run_cmd("zero_move", 1, 1, -1);
    run_cmd("clamp31", 31, 0, -1);
    run_cmd("clamp_clear5", 5, 0, -1);
    run_cmd("ignore_mid_move", 10, 1, 3);
    run_cmd("ignore_in_done", 12, 1, -2);

    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(0, 31));
      r = int'($urandom_range(0, 1));
      run_cmd($sformatf("rand%0d", i), a, r, -1);
    end

    run_cmd("home", 0, 1, -1);
    angle_tgt = 5'd5;
    refl_tgt  = 1'b0;
    cmd_load  = 1'b1;
    hits      = 0;
    for (int c = 0; c < 100 && hits == 0; c++) begin
      tick();
      cmd_load = 1'b0;
      if (pos == 5'd2) hits = 1;
    end
    chk("midmove:reached_pos2", hits, 1);
    chk("midmove:busy", busy, 1);
    res_n = 1'b0;
    tick();
    chk("midmove_reset:step", step, 0);
    chk("midmove_reset:busy", busy, 0);
    chk("midmove_reset:pos", pos, 0);
    chk("midmove_reset:refl_drive", refl_drive, 0);
    chk("midmove_reset:done", done, 0);
    res_n = 1'b1;
    dn    = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy || step) dn++;
    end
    chk("after_reset:quiet", dn, 0);
    m_pos  = 0;
    m_refl = 0;
    run_cmd("post_reset2", 2, 0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
